mouse_input_conditioner: RTL and testbench

- Sits between the mouse controller and main_State_Machine.
- Takes raw mouse button levels and raw cursor coordinates from the mouse controller and produces synchronised, debounced button levels plus single-cycle press/release pulses.
- Clamps the cursor position to the visible area and latches the cursor position at each left-button press.
- The debounced levels and clamped position drive the MouseLeft, MouseRight, xpos and ypos inputs of the screen state machine; the pulses and click position serve game-board logic.

---
 rtl/mouse_input_conditioner.sv | 223 ++++++++++++++++++++++
 tb/tb_mouse_input_conditioner.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_input_conditioner.sv
// Mouse input conditioning: button sync + debounce with edge pulses,
// cursor clamping to the visible area and click-position capture.
module mouse_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 65000,
    parameter int CNT_W           = 17,
    parameter int X_MAX           = 1023,
    parameter int Y_MAX           = 767
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        left_raw,
    input  logic        right_raw,
    input  logic [11:0] xpos_raw,
    input  logic [11:0] ypos_raw,
    output logic        MouseLeft,
    output logic        MouseRight,
    output logic        left_press,
    output logic        right_press,
    output logic        left_release,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [11:0] click_xpos,
    output logic [11:0] click_ypos
);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_RISE_CHK,
        ST_HIGH,
        ST_FALL_CHK
    } deb_state_t;

    localparam logic [CNT_W-1:0] C_DEB = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [11:0]      C_XMX = 12'(X_MAX);
    localparam logic [11:0]      C_YMX = 12'(Y_MAX);

    logic             r_left_m;
    logic             r_left_s;
    logic             r_right_m;
    logic             r_right_s;

    deb_state_t       r_l_state;
    logic [CNT_W-1:0] r_l_cnt;
    logic             r_l_level;
    logic             r_l_press;
    logic             r_l_release;

    deb_state_t       r_r_state;
    logic [CNT_W-1:0] r_r_cnt;
    logic             r_r_level;
    logic             r_r_press;

    logic [11:0]      r_xpos;
    logic [11:0]      r_ypos;
    logic [11:0]      r_click_x;
    logic [11:0]      r_click_y;

    logic             w_l_rise_done;
    logic [11:0]      w_x_clamp;
    logic [11:0]      w_y_clamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_left_m  <= 1'b0;
            r_left_s  <= 1'b0;
            r_right_m <= 1'b0;
            r_right_s <= 1'b0;
        end else begin
            r_left_m  <= left_raw;
            r_left_s  <= r_left_m;
            r_right_m <= right_raw;
            r_right_s <= r_right_m;
        end
    end

    assign w_l_rise_done = (r_l_state == ST_RISE_CHK) && r_left_s
                           && (r_l_cnt == C_DEB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_l_state   <= ST_LOW;
            r_l_cnt     <= '0;
            r_l_level   <= 1'b0;
            r_l_press   <= 1'b0;
            r_l_release <= 1'b0;
        end else begin
            r_l_press   <= 1'b0;
            r_l_release <= 1'b0;
            case (r_l_state)
                ST_LOW: begin
                    if (r_left_s) begin
                        r_l_cnt   <= CNT_W'(1);
                        r_l_state <= ST_RISE_CHK;
                    end
                end
                ST_RISE_CHK: begin
                    if (!r_left_s) begin
                        r_l_cnt   <= '0;
                        r_l_state <= ST_LOW;
                    end else if (r_l_cnt == C_DEB) begin
                        r_l_cnt   <= '0;
                        r_l_state <= ST_HIGH;
                        r_l_level <= 1'b1;
                        r_l_press <= 1'b1;
                    end else begin
                        r_l_cnt <= r_l_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!r_left_s) begin
                        r_l_cnt   <= CNT_W'(1);
                        r_l_state <= ST_FALL_CHK;
                    end
                end
                ST_FALL_CHK: begin
                    if (r_left_s) begin
                        r_l_cnt   <= '0;
                        r_l_state <= ST_HIGH;
                    end else if (r_l_cnt == C_DEB) begin
                        r_l_cnt     <= '0;
                        r_l_state   <= ST_LOW;
                        r_l_level   <= 1'b0;
                        r_l_release <= 1'b1;
                    end else begin
                        r_l_cnt <= r_l_cnt + 1'b1;
                    end
                end
                default: begin
                    r_l_cnt   <= '0;
                    r_l_state <= ST_LOW;
                    r_l_level <= 1'b0;
                end
            endcase
        end
    end

    // Right button mirrors the left FSM but has no release output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r_state <= ST_LOW;
            r_r_cnt   <= '0;
            r_r_level <= 1'b0;
            r_r_press <= 1'b0;
        end else begin
            r_r_press <= 1'b0;
            case (r_r_state)
                ST_LOW: begin
                    if (r_right_s) begin
                        r_r_cnt   <= CNT_W'(1);
                        r_r_state <= ST_RISE_CHK;
                    end
                end
                ST_RISE_CHK: begin
                    if (!r_right_s) begin
                        r_r_cnt   <= '0;
                        r_r_state <= ST_LOW;
                    end else if (r_r_cnt == C_DEB) begin
                        r_r_cnt   <= '0;
                        r_r_state <= ST_HIGH;
                        r_r_level <= 1'b1;
                        r_r_press <= 1'b1;
                    end else begin
                        r_r_cnt <= r_r_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!r_right_s) begin
                        r_r_cnt   <= CNT_W'(1);
                        r_r_state <= ST_FALL_CHK;
                    end
                end
                ST_FALL_CHK: begin
                    if (r_right_s) begin
                        r_r_cnt   <= '0;
                        r_r_state <= ST_HIGH;
                    end else if (r_r_cnt == C_DEB) begin
                        r_r_cnt   <= '0;
                        r_r_state <= ST_LOW;
                        r_r_level <= 1'b0;
                    end else begin
                        r_r_cnt <= r_r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_r_cnt   <= '0;
                    r_r_state <= ST_LOW;
                    r_r_level <= 1'b0;
                end
            endcase
        end
    end

    assign w_x_clamp = (xpos_raw > C_XMX) ? C_XMX : xpos_raw;
    assign w_y_clamp = (ypos_raw > C_YMX) ? C_YMX : ypos_raw;

    // Click registers sample the same clamped value xpos/ypos take this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xpos    <= '0;
            r_ypos    <= '0;
            r_click_x <= '0;
            r_click_y <= '0;
        end else begin
            r_xpos <= w_x_clamp;
            r_ypos <= w_y_clamp;
            if (w_l_rise_done) begin
                r_click_x <= w_x_clamp;
                r_click_y <= w_y_clamp;
            end
        end
    end

    assign MouseLeft    = r_l_level;
    assign MouseRight   = r_r_level;
    assign left_press   = r_l_press;
    assign right_press  = r_r_press;
    assign left_release = r_l_release;
    assign xpos         = r_xpos;
    assign ypos         = r_ypos;
    assign click_xpos   = r_click_x;
    assign click_ypos   = r_click_y;

endmodule

// File: tb/tb_mouse_input_conditioner.sv
// Directed bench for mouse_input_conditioner with DEBOUNCE_CYCLES=4:
// level latency is 6 cycles after the first sampling edge.
module tb_mouse_input_conditioner;

    logic        clk;
    logic        rst;
    logic        left_raw;
    logic        right_raw;
    logic [11:0] xpos_raw;
    logic [11:0] ypos_raw;
    logic        MouseLeft;
    logic        MouseRight;
    logic        left_press;
    logic        right_press;
    logic        left_release;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [11:0] click_xpos;
    logic [11:0] click_ypos;

    int checks;
    int errors;

    mouse_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(17),
        .X_MAX(1023),
        .Y_MAX(767)
    ) dut (
        .clk(clk),
        .rst(rst),
        .left_raw(left_raw),
        .right_raw(right_raw),
        .xpos_raw(xpos_raw),
        .ypos_raw(ypos_raw),
        .MouseLeft(MouseLeft),
        .MouseRight(MouseRight),
        .left_press(left_press),
        .right_press(right_press),
        .left_release(left_release),
        .xpos(xpos),
        .ypos(ypos),
        .click_xpos(click_xpos),
        .click_ypos(click_ypos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        left_raw = 1'b1;
        right_raw = 1'b0;
        xpos_raw = 12'd500;
        ypos_raw = 12'd100;
        repeat (4) tick();
        checks++;
        if ({MouseLeft, MouseRight, left_press, right_press, left_release} !== 5'b0) begin
            errors++;
            $display("FAIL reset_levels got %b want 00000",
                     {MouseLeft, MouseRight, left_press, right_press, left_release});
        end
        checks++;
        if ({xpos, ypos, click_xpos, click_ypos} !== 48'd0) begin
            errors++;
            $display("FAIL reset_pos got %0d %0d %0d %0d want 0 0 0 0",
                     xpos, ypos, click_xpos, click_ypos);
        end
        rst = 1'b1;
        repeat (6) tick();
        checks++;
        if (MouseLeft !== 1'b0 || left_press !== 1'b0) begin
            errors++;
            $display("FAIL reset_early got lvl=%b prs=%b want 0 0", MouseLeft, left_press);
        end
        tick();
        checks++;
        if (MouseLeft !== 1'b1 || left_press !== 1'b1 || click_xpos !== 12'd500) begin
            errors++;
            $display("FAIL reset_rise got lvl=%b prs=%b cx=%0d want 1 1 500",
                     MouseLeft, left_press, click_xpos);
        end
        tick();
        checks++;
        if (left_press !== 1'b0 || MouseLeft !== 1'b1) begin
            errors++;
            $display("FAIL reset_pulse1 got prs=%b lvl=%b want 0 1", left_press, MouseLeft);
        end
    endtask

    task automatic test_release();
        left_raw = 1'b0;
        repeat (6) tick();
        checks++;
        if (MouseLeft !== 1'b1 || left_release !== 1'b0) begin
            errors++;
            $display("FAIL rel_early got lvl=%b rel=%b want 1 0", MouseLeft, left_release);
        end
        tick();
        checks++;
        if (MouseLeft !== 1'b0 || left_release !== 1'b1) begin
            errors++;
            $display("FAIL rel_fall got lvl=%b rel=%b want 0 1", MouseLeft, left_release);
        end
    endtask

    task automatic test_glitch();
        int bad;
        int rels;
        bad = 0;
        left_raw = 1'b1;
        repeat (3) begin tick(); bad += int'(MouseLeft | left_press | left_release); end
        left_raw = 1'b0;
        tick(); bad += int'(MouseLeft | left_press | left_release);
        left_raw = 1'b1;
        repeat (3) begin tick(); bad += int'(MouseLeft | left_press | left_release); end
        left_raw = 1'b0;
        repeat (10) begin tick(); bad += int'(MouseLeft | left_press | left_release); end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL glitch got %0d active cycles want 0", bad);
        end
        left_raw = 1'b1;
        repeat (10) tick();
        checks++;
        if (MouseLeft !== 1'b1) begin
            errors++;
            $display("FAIL clean_high got %b want 1", MouseLeft);
        end
        left_raw = 1'b0;
        rels = 0;
        repeat (6) begin tick(); rels += int'(left_release); end
        checks++;
        if (MouseLeft !== 1'b1 || rels !== 0) begin
            errors++;
            $display("FAIL clean_hold got lvl=%b rels=%0d want 1 0", MouseLeft, rels);
        end
        repeat (6) begin tick(); rels += int'(left_release); end
        checks++;
        if (MouseLeft !== 1'b0 || rels !== 1) begin
            errors++;
            $display("FAIL clean_fall got lvl=%b rels=%0d want 0 1", MouseLeft, rels);
        end
    endtask

    task automatic test_clamp();
        logic [11:0] vx [5];
        logic [11:0] vy [5];
        logic [11:0] ex [5];
        logic [11:0] ey [5];
        vx = '{12'd1500, 12'd1023, 12'd0, 12'd1024, 12'd4095};
        vy = '{12'd800,  12'd767,  12'd0, 12'd768,  12'd4095};
        ex = '{12'd1023, 12'd1023, 12'd0, 12'd1023, 12'd1023};
        ey = '{12'd767,  12'd767,  12'd0, 12'd767,  12'd767};
        for (int i = 0; i < 5; i++) begin
            xpos_raw = vx[i];
            ypos_raw = vy[i];
            tick();
            checks++;
            if (xpos !== ex[i] || ypos !== ey[i]) begin
                errors++;
                $display("FAIL clamp%0d got %0d/%0d want %0d/%0d",
                         i, xpos, ypos, ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_click();
        xpos_raw = 12'd300;
        ypos_raw = 12'd200;
        left_raw = 1'b1;
        repeat (7) tick();
        checks++;
        if (left_press !== 1'b1 || click_xpos !== 12'd300 || click_ypos !== 12'd200) begin
            errors++;
            $display("FAIL click_cap got prs=%b %0d/%0d want 1 300/200",
                     left_press, click_xpos, click_ypos);
        end
        xpos_raw = 12'd900;
        ypos_raw = 12'd700;
        tick();
        checks++;
        if (xpos !== 12'd900 || ypos !== 12'd700
            || click_xpos !== 12'd300 || click_ypos !== 12'd200) begin
            errors++;
            $display("FAIL click_hold got pos %0d/%0d click %0d/%0d want 900/700 300/200",
                     xpos, ypos, click_xpos, click_ypos);
        end
        left_raw = 1'b0;
        repeat (8) tick();
        checks++;
        if (MouseLeft !== 1'b0 || click_xpos !== 12'd300 || click_ypos !== 12'd200) begin
            errors++;
            $display("FAIL click_rel got lvl=%b click %0d/%0d want 0 300/200",
                     MouseLeft, click_xpos, click_ypos);
        end
    endtask

    task automatic test_simultaneous();
        int lrel;
        left_raw = 1'b1;
        right_raw = 1'b1;
        repeat (6) tick();
        checks++;
        if (left_press !== 1'b0 || right_press !== 1'b0) begin
            errors++;
            $display("FAIL sim_early got %b%b want 00", left_press, right_press);
        end
        tick();
        checks++;
        if ({left_press, right_press, MouseLeft, MouseRight} !== 4'b1111) begin
            errors++;
            $display("FAIL sim_press got %b want 1111",
                     {left_press, right_press, MouseLeft, MouseRight});
        end
        right_raw = 1'b0;
        lrel = 0;
        repeat (10) begin tick(); lrel += int'(left_release | left_press); end
        checks++;
        if (MouseRight !== 1'b0 || MouseLeft !== 1'b1 || lrel !== 0) begin
            errors++;
            $display("FAIL sim_right_rel got R=%b L=%b lpulses=%0d want 0 1 0",
                     MouseRight, MouseLeft, lrel);
        end
    endtask

    task automatic test_reset_mid();
        int prs;
        left_raw = 1'b0;
        repeat (8) tick();
        checks++;
        if (MouseLeft !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre got %b want 0", MouseLeft);
        end
        left_raw = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (MouseLeft !== 1'b0 || left_press !== 1'b0 || xpos !== 12'd0
            || click_xpos !== 12'd0) begin
            errors++;
            $display("FAIL mid_rst got lvl=%b prs=%b x=%0d cx=%0d want 0 0 0 0",
                     MouseLeft, left_press, xpos, click_xpos);
        end
        repeat (2) tick();
        rst = 1'b1;
        prs = 0;
        repeat (6) begin tick(); prs += int'(left_press | MouseLeft); end
        checks++;
        if (prs !== 0) begin
            errors++;
            $display("FAIL mid_latency got %0d early cycles want 0", prs);
        end
        tick();
        checks++;
        if (MouseLeft !== 1'b1 || left_press !== 1'b1) begin
            errors++;
            $display("FAIL mid_rise got lvl=%b prs=%b want 1 1", MouseLeft, left_press);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_release();
        test_glitch();
        test_clamp();
        test_click();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
